// File: rtl/rf_wb_scheduler_if.sv
// Register-file write-port bundle: WB stage, MDU result handshake, decode
// hazard query and the shared register-file write port.
interface rf_wb_scheduler_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          wb_we;
  logic [AW-1:0] wb_rw;
  logic [DW-1:0] wb_busw;
  logic          wb_ovf;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_rw;
  logic [DW-1:0] md_data;
  logic          md_issue;
  logic [AW-1:0] md_issue_rd;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic          id_hazard;
  logic          wb_hold;
  logic          rf_regwr;
  logic [AW-1:0] rf_rw;
  logic [DW-1:0] rf_busw;
  logic          rf_overflow;

  modport slave (
    input  wb_we, wb_rw, wb_busw, wb_ovf,
    input  md_valid, md_rw, md_data,
    input  md_issue, md_issue_rd, id_rs, id_rt, id_rd,
    output md_ready, id_hazard, wb_hold,
    output rf_regwr, rf_rw, rf_busw, rf_overflow
  );

  modport master (
    output wb_we, wb_rw, wb_busw, wb_ovf,
    output md_valid, md_rw, md_data,
    output md_issue, md_issue_rd, id_rs, id_rt, id_rd,
    input  md_ready, id_hazard, wb_hold,
    input  rf_regwr, rf_rw, rf_busw, rf_overflow
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port between WB and a buffered MDU result
// stream; tracks pending MDU destinations for decode RAW/WAW stalls.
module rf_wb_scheduler #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_wb_scheduler_if.slave  bus
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW   = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_HEAD} src_t;

  logic [AW-1:0]   fifo_rw   [FIFO_DEPTH];
  logic [DW-1:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [SW-1:0]   starve_cnt;
  logic [NREG-1:0] busy;

  logic            empty, full, wb_active, steal;
  logic            push, pop, ready, hazard, hold, regwr;
  logic [AW-1:0]   head_rw;
  logic [DW-1:0]   head_data;
  logic [NREG-1:0] busy_set, busy_clr;
  src_t            src;

  always_comb begin
    empty     = (count == '0);
    full      = (count == (PW+1)'(FIFO_DEPTH));
    head_rw   = fifo_rw[rd_ptr];
    head_data = fifo_data[rd_ptr];
    wb_active = bus.wb_we & (bus.wb_rw != '0) & ~bus.wb_ovf;
    steal     = ~empty & (starve_cnt == SW'(STARVE_MAX - 1));

    src  = SRC_NONE;
    hold = 1'b0;
    if (steal) begin
      src  = SRC_HEAD;
      hold = wb_active;
    end else if (wb_active) begin
      src = SRC_WB;
    end else if (!empty) begin
      src = SRC_HEAD;
    end

    regwr = rst_n & (src != SRC_NONE);
    pop   = rst_n & (src == SRC_HEAD);
    ready = rst_n & ~full;
    push  = bus.md_valid & ready & (bus.md_rw != '0);

    // The issue term only matters when md_issue is asserted; the id_rd term
    // keeps a WB write from overtaking a pending MDU write (WAW).
    hazard = rst_n & (busy[bus.id_rs] | busy[bus.id_rt] |
                      (bus.md_issue & busy[bus.md_issue_rd]) | busy[bus.id_rd]);

    busy_set = '0;
    if (bus.md_issue & ~hazard & (bus.md_issue_rd != '0))
      busy_set[bus.md_issue_rd] = 1'b1;
    busy_clr = '0;
    if (pop)
      busy_clr[head_rw] = 1'b1;
  end

  always_comb begin
    bus.rf_rw       = bus.wb_rw;
    bus.rf_busw     = bus.wb_busw;
    bus.rf_overflow = bus.wb_ovf;
    if (src == SRC_HEAD) begin
      bus.rf_rw       = head_rw;
      bus.rf_busw     = head_data;
      bus.rf_overflow = 1'b0;
    end
  end

  assign bus.rf_regwr  = regwr;
  assign bus.wb_hold   = hold & rst_n;
  assign bus.md_ready  = ready;
  assign bus.id_hazard = hazard;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rw[wr_ptr]   <= bus.md_rw;
      fifo_data[wr_ptr] <= bus.md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (empty || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX - 1))
        starve_cnt <= starve_cnt + SW'(1);
      // Set overrides clear so a re-issue racing the old pop stays tracked.
      busy <= ((busy & ~busy_clr) | busy_set) & ~NREG'(1);
    end
  end

endmodule
